// File: rtl/dfd_packetizer_pkg.sv
// Shared types for the trace packetizer: accumulator bank status and drain FSM states.
package dfd_packetizer_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_PARTIAL = 2'd1,
    BANK_FULL    = 2'd2
  } bank_status_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_SEND  = 2'd1,
    DRAIN_FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/dfd_accumulator_drain.sv
// Drains FULL accumulator banks in strict round-robin order onto a valid/ready trace sink,
// flushing each drained bank back to EMPTY and acknowledging force_drain requests.
module dfd_accumulator_drain
  import dfd_packetizer_pkg::*;
#(
  parameter int unsigned NUM_BANKS                = 4,
  parameter int unsigned BANK_DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned BEAT_COUNT_WIDTH         = 16,
  localparam int unsigned DATA_W = BANK_DATA_WIDTH_IN_BYTES * 8,
  localparam int unsigned ID_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  bank_status_t [NUM_BANKS-1:0]            bank_status,
  input  logic         [NUM_BANKS*DATA_W-1:0]     bank_data_out,
  input  logic                                    force_drain,
  output logic         [NUM_BANKS-1:0]            bank_flush,
  output logic                                    drain_valid,
  input  logic                                    drain_ready,
  output logic         [DATA_W-1:0]               drain_data,
  output logic         [ID_W-1:0]                 drain_bank_id,
  output logic                                    drain_done,
  output logic         [BEAT_COUNT_WIDTH-1:0]     drain_beat_count
);

  drain_state_t        state;
  logic [ID_W-1:0]     rd_ptr;
  logic                drain_pending;
  bank_status_t        sel_status;
  logic [DATA_W-1:0]   sel_data;
  logic                rd_full;
  logic                idle_not_full;

  // Only the bank at rd_ptr is ever examined; out-of-enum codes fall through as not FULL.
  always_comb begin
    sel_status = BANK_EMPTY;
    sel_data   = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (ID_W'(i) == rd_ptr) begin
        sel_status = bank_status[i];
        sel_data   = bank_data_out[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_full       = (sel_status == BANK_FULL);
  assign idle_not_full = (state == DRAIN_IDLE) && !rd_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= DRAIN_IDLE;
      rd_ptr           <= '0;
      drain_pending    <= 1'b0;
      bank_flush       <= '0;
      drain_valid      <= 1'b0;
      drain_data       <= '0;
      drain_bank_id    <= '0;
      drain_done       <= 1'b0;
      drain_beat_count <= '0;
    end else begin
      bank_flush <= '0;
      drain_done <= 1'b0;

      case (state)
        DRAIN_IDLE: begin
          if (rd_full) begin
            drain_data    <= sel_data;
            drain_bank_id <= rd_ptr;
            drain_valid   <= 1'b1;
            state         <= DRAIN_SEND;
          end
        end
        DRAIN_SEND: begin
          if (drain_ready) begin
            drain_valid <= 1'b0;
            bank_flush  <= NUM_BANKS'(1) << rd_ptr;
            if (drain_beat_count != '1) begin
              drain_beat_count <= drain_beat_count + 1'b1;
            end
            state <= DRAIN_FLUSH;
          end
        end
        DRAIN_FLUSH: begin
          // Pointer advances on the same edge the bank's status drops, so IDLE sees fresh status.
          rd_ptr <= (rd_ptr == ID_W'(NUM_BANKS - 1)) ? '0 : rd_ptr + 1'b1;
          state  <= DRAIN_IDLE;
        end
        default: state <= DRAIN_IDLE;
      endcase

      if (drain_pending && idle_not_full) begin
        drain_done <= 1'b1;
      end

      // A new request arriving alongside completion re-arms the pending flag.
      if (force_drain) begin
        drain_pending <= 1'b1;
      end else if (idle_not_full) begin
        drain_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dfd_accumulator_drain.sv
// Self-checking bench for dfd_accumulator_drain: directed scenarios plus randomized bank traffic
// checked every cycle against a transaction-level model of the drain rules.
module tb_dfd_accumulator_drain;
  import dfd_packetizer_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 128;
  localparam int CW   = 4;
  localparam int IDW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  bank_status_t [N-1:0]   bank_status;
  logic [N*DW-1:0]        bank_data_out;
  logic                   force_drain = 1'b0;
  logic [N-1:0]           bank_flush;
  logic                   drain_valid;
  logic                   drain_ready = 1'b0;
  logic [DW-1:0]          drain_data;
  logic [IDW-1:0]         drain_bank_id;
  logic                   drain_done;
  logic [CW-1:0]          drain_beat_count;

  dfd_accumulator_drain #(
    .NUM_BANKS(N),
    .BANK_DATA_WIDTH_IN_BYTES(16),
    .BEAT_COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bank_status(bank_status),
    .bank_data_out(bank_data_out),
    .force_drain(force_drain),
    .bank_flush(bank_flush),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_data(drain_data),
    .drain_bank_id(drain_bank_id),
    .drain_done(drain_done),
    .drain_beat_count(drain_beat_count)
  );

  always #5 clock = ~clock;

  bank_status_t  st [N];
  logic [DW-1:0] dat [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bank_status[i]            = st[i];
      bank_data_out[i*DW +: DW] = dat[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one outstanding beat at a time, taken from the bank the pointer names; the cycle after
  // acceptance is the flush cycle, after which the pointer moves on.
  logic          m_valid, m_done, m_pending;
  logic [N-1:0]  m_flush, flush_req;
  logic [DW-1:0] m_data;
  int            m_ptr, m_id, m_count;

  always @(negedge clock) begin
    logic idle, full, hs, n_valid;
    logic [N-1:0] n_flush;
    if (!reset_n) begin
      chk("rst_valid", drain_valid, 0);
      chk("rst_flush", bank_flush, 0);
      chk("rst_data", drain_data, 0);
      chk("rst_id", drain_bank_id, 0);
      chk("rst_done", drain_done, 0);
      chk("rst_count", drain_beat_count, 0);
      m_valid = 0; m_done = 0; m_pending = 0; m_flush = '0; m_data = '0;
      m_ptr = 0; m_id = 0; m_count = 0; flush_req = '0;
    end else begin
      chk("valid", drain_valid, m_valid);
      if (m_valid) begin
        chk("bank_id", drain_bank_id, m_id);
        chk("data", drain_data, m_data);
      end
      chk("flush", bank_flush, m_flush);
      chk("done", drain_done, m_done);
      chk("count", drain_beat_count, m_count);

      idle    = !m_valid && (m_flush == '0);
      full    = (st[m_ptr] == BANK_FULL);
      hs      = m_valid && drain_ready;
      n_valid = m_valid ? !drain_ready : (idle && full);
      if (idle && full) begin
        m_data = dat[m_ptr];
        m_id   = m_ptr;
      end
      n_flush   = hs ? N'(1 << m_ptr) : '0;
      flush_req = m_flush;
      if (m_flush != '0) m_ptr = (m_ptr + 1) % N;
      m_done    = m_pending && idle && !full;
      m_pending = force_drain || (m_pending && !(idle && !full));
      if (hs && m_count < CMAX) m_count++;
      m_valid = n_valid;
      m_flush = n_flush;
    end
  end

  bit rand_mode = 0;
  int cyc = 0;

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (flush_req[i]) st[i] = BANK_EMPTY;
    if (rand_mode) begin
      drain_ready = ($urandom_range(0, 9) < 7);
      force_drain = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (st[i] != BANK_FULL && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0:       st[i] = BANK_PARTIAL;
            1:       st[i] = bank_status_t'(2'b11);
            default: begin
              st[i]  = BANK_FULL;
              dat[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
          endcase
        end
      end
    end
    cyc++;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int k = 0; k < budget && !drain_valid; k++) step();
    chk(name, drain_valid, 1);
  endtask

  initial begin
    int ids[$];
    int cycs[$];
    logic [N-1:0] flushes[$];
    logic [DW-1:0] hold;
    int cnt, cnt2, beats;
    logic [N-1:0] fl;
    logic [DW-1:0] lit;

    for (int i = 0; i < N; i++) begin st[i] = BANK_EMPTY; dat[i] = '0; end
    repeat (3) step();
    reset_n = 1'b1;

    // 1: single FULL bank, known payload
    lit = 128'h0F0E0D0C0B0A09080706050403020100;
    st[0] = BANK_FULL; dat[0] = lit; drain_ready = 1'b1;
    step();
    chk("t1_valid", drain_valid, 1);
    chk("t1_data", drain_data, lit);
    chk("t1_id", drain_bank_id, 0);
    step();
    chk("t1_flush", bank_flush, 4'b0001);
    chk("t1_valid_drop", drain_valid, 0);
    step();
    chk("t1_flush_end", bank_flush, 0);
    chk("t1_count", drain_beat_count, 1);

    // 2: all banks FULL, in-order from pointer 1, one beat every 3 cycles
    for (int i = 0; i < N; i++) begin st[i] = BANK_FULL; dat[i] = {4{32'hA0 + 32'(i)}}; end
    for (int k = 0; k < 40 && ids.size() < 4; k++) begin
      step();
      if (bank_flush != '0) flushes.push_back(bank_flush);
      if (drain_valid && drain_ready) begin ids.push_back(drain_bank_id); cycs.push_back(cyc); end
    end
    step();
    if (bank_flush != '0) flushes.push_back(bank_flush);
    chk("t2_beats", ids.size(), 4);
    chk("t2_flushes", flushes.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("t2_id%0d", i), ids[i], (i + 1) % 4);
    for (int i = 0; i < flushes.size(); i++) chk($sformatf("t2_fl%0d", i), flushes[i], 4'b0001 << ((i + 1) % 4));
    for (int i = 1; i < cycs.size(); i++) chk($sformatf("t2_gap%0d", i), cycs[i] - cycs[i-1], 3);
    step();
    chk("t2_count", drain_beat_count, 5);

    // 3: backpressure holds the beat stable, then exactly one flush
    hold = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    drain_ready = 1'b0; st[1] = BANK_FULL; dat[1] = hold;
    wait_valid("t3_wait", 10);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hold_valid", drain_valid, 1);
      chk("t3_hold_data", drain_data, hold);
      chk("t3_hold_id", drain_bank_id, 1);
      chk("t3_no_flush", bank_flush, 0);
    end
    drain_ready = 1'b1;
    cnt = 0; fl = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bank_flush != '0) begin cnt++; fl = bank_flush; end
    end
    chk("t3_flush_cnt", cnt, 1);
    chk("t3_flush_val", fl, 4'b0010);

    // 4: FULL bank behind a PARTIAL one waits
    st[2] = BANK_PARTIAL; st[3] = BANK_FULL;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (drain_valid || bank_flush != '0) cnt++;
    end
    chk("t4_blocked", cnt, 0);
    st[2] = BANK_FULL;
    ids.delete();
    for (int k = 0; k < 20 && ids.size() < 2; k++) begin
      step();
      if (drain_valid && drain_ready) ids.push_back(drain_bank_id);
    end
    chk("t4_beats", ids.size(), 2);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("t4_id%0d", i), ids[i], 2 + i);
    step();

    // 5: force_drain stops at the PARTIAL bank
    st[0] = BANK_FULL; st[1] = BANK_FULL; st[2] = BANK_PARTIAL; st[3] = BANK_EMPTY;
    force_drain = 1'b1;
    step();
    force_drain = 1'b0;
    beats = 0; cnt = 0; cnt2 = 0;
    for (int k = 0; k < 30 && cnt == 0; k++) begin
      step();
      force_drain = (k == 1);
      if (drain_valid && drain_ready) beats++;
      if (bank_flush[2]) cnt2++;
      if (drain_done) begin cnt++; chk("t5_done_idle", drain_valid, 0); end
    end
    force_drain = 1'b0;
    chk("t5_done_seen", cnt, 1);
    chk("t5_beats", beats, 2);
    for (int k = 0; k < 4; k++) begin
      step();
      if (drain_done) cnt++;
      if (bank_flush[2]) cnt2++;
    end
    chk("t5_done_once", cnt, 1);
    chk("t5_bank2_untouched", cnt2, 0);
    chk("t5_count", drain_beat_count, 10);

    // 6: counter saturation, then reset during SEND
    beats = 0;
    for (int k = 0; k < 100 && beats < 8; k++) begin
      step();
      for (int i = 0; i < N; i++) if (st[i] != BANK_FULL) begin st[i] = BANK_FULL; dat[i] = {4{$urandom()}}; end
      if (drain_valid && drain_ready) beats++;
    end
    step(); step();
    chk("t6_saturated", drain_beat_count, 4'hF);
    drain_ready = 1'b0;
    wait_valid("t6_wait", 10);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", drain_valid, 0);
    chk("t6_async_flush", bank_flush, 0);
    chk("t6_async_count", drain_beat_count, 0);
    step(); step();
    for (int i = 0; i < N; i++) st[i] = BANK_FULL;
    reset_n = 1'b1; drain_ready = 1'b1;
    wait_valid("t6_post_wait", 10);
    chk("t6_post_id", drain_bank_id, 0);

    // randomized traffic, model-checked every cycle
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    drain_ready = 1'b1; force_drain = 1'b0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (got hang, expected finish)");
    $fatal(1);
  end

endmodule
